// File: rtl/run_length_counter.sv
// Run-length event extractor for the JPEG-LS run-mode path: turns per-lane status
// codes into run-length events, with a 2-stage pass-through of pixel/context data.
module run_length_counter #(
    parameter int RLW = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           ena,
    input  logic           i_sl,
    input  logic           i_sp,
    input  logic           i_vl,
    input  logic [1:0]     i_st [1:8],
    input  logic [7:0]     i_b  [1:9],
    input  logic [7:0]     i_x  [1:8],
    output logic           o_sl,
    output logic           o_sp,
    output logic           o_vl,
    output logic [1:0]     o_st [1:8],
    output logic [7:0]     o_b  [1:9],
    output logic [7:0]     o_x  [1:8],
    output logic           o_re [1:8],
    output logic           o_rt [1:8],
    output logic [RLW-1:0] o_rl [1:8],
    output logic           o_err
);

    localparam logic [RLW-1:0] RL_MAX = '1;

    // Stage A: raw input capture
    logic           a_sl_reg;
    logic           a_sp_reg;
    logic           a_vl_reg;
    logic [1:0]     a_st_reg [1:8];
    logic [7:0]     a_b_reg  [1:9];
    logic [7:0]     a_x_reg  [1:8];

    // Run count carried between beats
    logic [RLW-1:0] acc_reg;
    logic [RLW-1:0] acc_next;

    logic [RLW-1:0] walk_c;
    logic           err_next;
    logic           re_next [1:8];
    logic           rt_next [1:8];
    logic [RLW-1:0] rl_next [1:8];

    function automatic logic [RLW-1:0] sat_inc(input logic [RLW-1:0] v);
        return (v == RL_MAX) ? v : v + RLW'(1);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_sl_reg <= 1'b0;
            a_sp_reg <= 1'b0;
            a_vl_reg <= 1'b0;
            for (int i = 1; i <= 8; i++) begin
                a_st_reg[i] <= '0;
                a_x_reg[i]  <= '0;
            end
            for (int i = 1; i <= 9; i++) begin
                a_b_reg[i] <= '0;
            end
        end else if (ena) begin
            a_sl_reg <= i_sl;
            a_sp_reg <= i_sp;
            a_vl_reg <= i_vl;
            for (int i = 1; i <= 8; i++) begin
                a_st_reg[i] <= i_st[i];
                a_x_reg[i]  <= i_x[i];
            end
            for (int i = 1; i <= 9; i++) begin
                a_b_reg[i] <= i_b[i];
            end
        end
    end

    // Lane walk: a segment start discards any run carried from the previous beat
    always_comb begin
        walk_c   = a_sp_reg ? '0 : acc_reg;
        err_next = o_err;
        acc_next = acc_reg;
        for (int i = 1; i <= 8; i++) begin
            re_next[i] = 1'b0;
            rt_next[i] = 1'b0;
            rl_next[i] = '0;
        end
        if (a_vl_reg) begin
            for (int i = 1; i <= 8; i++) begin
                case (a_st_reg[i])
                    2'd1: walk_c = sat_inc(walk_c);
                    2'd2: begin
                        re_next[i] = 1'b1;
                        rl_next[i] = walk_c;
                        walk_c     = '0;
                    end
                    2'd3: begin
                        re_next[i] = 1'b1;
                        rt_next[i] = 1'b1;
                        rl_next[i] = sat_inc(walk_c);
                        walk_c     = '0;
                    end
                    default: begin
                        // A regular pixel while a run is open means the run was never terminated
                        if (walk_c != '0) begin
                            err_next = 1'b1;
                        end
                        walk_c = '0;
                    end
                endcase
            end
            acc_next = walk_c;
        end
    end

    // Stage B: output registers and run accumulator
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_sl    <= 1'b0;
            o_sp    <= 1'b0;
            o_vl    <= 1'b0;
            o_err   <= 1'b0;
            acc_reg <= '0;
            for (int i = 1; i <= 8; i++) begin
                o_st[i] <= '0;
                o_x[i]  <= '0;
                o_re[i] <= 1'b0;
                o_rt[i] <= 1'b0;
                o_rl[i] <= '0;
            end
            for (int i = 1; i <= 9; i++) begin
                o_b[i] <= '0;
            end
        end else if (ena) begin
            o_sl    <= a_sl_reg;
            o_sp    <= a_sp_reg;
            o_vl    <= a_vl_reg;
            o_err   <= err_next;
            acc_reg <= acc_next;
            for (int i = 1; i <= 8; i++) begin
                o_st[i] <= a_st_reg[i];
                o_x[i]  <= a_x_reg[i];
                o_re[i] <= re_next[i];
                o_rt[i] <= rt_next[i];
                o_rl[i] <= rl_next[i];
            end
            for (int i = 1; i <= 9; i++) begin
                o_b[i] <= a_b_reg[i];
            end
        end
    end

endmodule
